mux41_4_arb: RTL and testbench

Round-robin arbiter that shares one 4:1 4-bit word multiplexer (`mux41_4`) among four requesters. It issues a one-hot grant and drives the mux select. It captures the selected word into a registered output with a valid/ready handshake and returns a one-cycle acknowledge to the served requester. The block sits between four producer channels and a single 4-bit consumer, and is the sequencing logic for the existing mux datapath.

---
 rtl/mux41_4_arb_pkg.sv | 16 +
 rtl/mux41_4.sv | 25 ++
 rtl/mux41_4_arb_rr_pick4.sv | 33 +++
 rtl/mux41_4_arb.sv | 163 ++++++++++++++++
 tb/tb_mux41_4_arb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux41_4_arb_pkg.sv
// mux41_4_arb_pkg: shared types and constants for the mux41_4 round-robin arbiter.
//   state_e       - arbiter FSM states
//   NumCh, DataW  - channel count and data word width
//   BurstMaxLimit - upper bound accepted for the BURST_MAX parameter
package mux41_4_arb_pkg;

  localparam int unsigned NumCh         = 4;
  localparam int unsigned DataW         = 4;
  localparam int unsigned BurstMaxLimit = 16;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } state_e;

endpackage

// File: rtl/mux41_4.sv
// mux41_4: 4:1 multiplexer of 4-bit words.
//   w0..w3 : data words
//   sel    : word select
//   y      : selected word (combinational)
module mux41_4 (
  input  logic [3:0] w0,
  input  logic [3:0] w1,
  input  logic [3:0] w2,
  input  logic [3:0] w3,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = w0;
    unique case (sel)
      2'd0: y = w0;
      2'd1: y = w1;
      2'd2: y = w2;
      2'd3: y = w3;
      default: y = w0;
    endcase
  end

endmodule

// File: rtl/mux41_4_arb_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   req : request vector
//   ptr : highest-priority channel
//   gnt : one-hot winner, zero when no request
//   idx : encoded winner (meaningful only when gnt != 0)
module rr_pick4
  import mux41_4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  // Scan ptr, ptr+1, ptr+2, ptr+3 with natural 2-bit wrap.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < int'(NumCh); i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    gnt = found ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/mux41_4_arb.sv
// mux41_4_arb: round-robin arbiter sharing one mux41_4 among four requesters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req, lock    : per-channel request / burst-continue hint
//   w0..w3       : channel data words
//   out_ready    : consumer accepts y this cycle
//   gnt, sel     : one-hot grant and encoded mux select
//   ack          : one-cycle pulse on the channel whose word was loaded into y
//   y, y_valid   : registered output word and its valid flag
//   busy         : FSM is transferring
// Build option: define MUX41_4_ARB_BURST_EN to let a locked channel keep its grant
// for up to BURST_MAX beats; otherwise lock is ignored and each grant is one beat.
module mux41_4_arb
  import mux41_4_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic [3:0] w0,
  input  logic [3:0] w1,
  input  logic [3:0] w2,
  input  logic [3:0] w3,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] ack,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] y_q, y_d;
  logic       y_valid_q, y_valid_d;

  logic [3:0] pick_gnt;
  logic [1:0] pick_idx;
  logic [3:0] mux_y;
  logic       load;
  logic       last_beat;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  mux41_4 u_mux (
    .w0  (w0),
    .w1  (w1),
    .w2  (w2),
    .w3  (w3),
    .sel (sel_q),
    .y   (mux_y)
  );

  // The output register is free if empty or being drained this cycle.
  assign load = (state_q == StXfer) && (!y_valid_q || out_ready);

`ifdef MUX41_4_ARB_BURST_EN
  localparam int unsigned BeatW = $clog2(BurstMaxLimit + 1);

  logic [BeatW-1:0] beat_q, beat_d;

  // beat_q counts beats already delivered under the current grant.
  always_comb begin
    beat_d    = beat_q;
    last_beat = 1'b1;
    if (state_q == StIdle) begin
      beat_d = '0;
    end else if (load && lock[sel_q] && ((32'(beat_q) + 32'd1) < BURST_MAX)) begin
      last_beat = 1'b0;
      beat_d    = beat_q + BeatW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  logic [4:0] unused_cfg;

  assign last_beat  = 1'b1;
  assign unused_cfg = {^lock, 4'(BURST_MAX)};
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ack_d     = '0;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    // Consume; a same-cycle load below overrides this.
    if (y_valid_q && out_ready) begin
      y_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (load) begin
          y_d       = mux_y;
          y_valid_d = 1'b1;
          ack_d     = gnt_q;
          if (last_beat) begin
            ptr_d   = sel_q + 2'd1;
            gnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      ack_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign ack     = ack_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == StXfer);

endmodule

// File: tb/tb_mux41_4_arb.sv
// tb_mux41_4_arb: self-checking bench for mux41_4_arb. Table-driven single-grant vectors
// plus hand-written multi-cycle sequences; every ack is checked against a scoreboard queue.
module tb_mux41_4_arb;

`ifdef MUX41_4_ARB_BURST_EN
  localparam int ExpBeats = 4;
`else
  localparam int ExpBeats = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] w0, w1, w2, w3;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] ack;
  logic [3:0] y;
  logic       y_valid;
  logic       busy;

  mux41_4_arb #(
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] y;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] ws;   // {w3, w2, w1, w0}
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  y;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare any ack against the next expected beat.
  task automatic sb_check();
    exp_t e;
    if (ack != 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_ack: got ack=%b y=%h, required no ack", ack, y);
      end else begin
        e = exp_q.pop_front();
        check("sb_ack", 32'(ack), 32'(e.ack));
        check("sb_y", 32'(y), 32'(e.y));
        check("sb_y_valid", 32'(y_valid), 1);
      end
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    e.ack = a;
    e.y   = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic set_words(input logic [15:0] ws);
    w0 = ws[3:0];
    w1 = ws[7:4];
    w2 = ws[11:8];
    w3 = ws[15:12];
  endtask

  initial begin
    int cnt2, cnt0, first2, last2, cyc;
    n_cmp = 0;
    n_err = 0;

    // ptr starts at 0 after the all-request sequence; winners follow from that.
    vecs[0] = '{req: 4'b0010, ws: 16'h00A0, gnt: 4'b0010, sel: 2'd1, y: 4'hA};
    vecs[1] = '{req: 4'b1111, ws: 16'h4321, gnt: 4'b0100, sel: 2'd2, y: 4'h3};
    vecs[2] = '{req: 4'b0011, ws: 16'h8765, gnt: 4'b0001, sel: 2'd0, y: 4'h5};
    vecs[3] = '{req: 4'b1001, ws: 16'hDCB9, gnt: 4'b1000, sel: 2'd3, y: 4'hD};
    vecs[4] = '{req: 4'b0100, ws: 16'h21FE, gnt: 4'b0100, sel: 2'd2, y: 4'h1};
    vecs[5] = '{req: 4'b1000, ws: 16'h7000, gnt: 4'b1000, sel: 2'd3, y: 4'h7};
    vecs[6] = '{req: 4'b0110, ws: 16'h65C3, gnt: 4'b0010, sel: 2'd1, y: 4'hC};
    vecs[7] = '{req: 4'b0001, ws: 16'h000F, gnt: 4'b0001, sel: 2'd0, y: 4'hF};

    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    out_ready = 1'b0;
    set_words(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset release, idle.
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset_idle", 32'({gnt, sel, ack, y, y_valid, busy}), 0);
    end

    // All channels requesting: ack order 0,1,2,3.
    out_ready = 1'b1;
    set_words(16'h4321);
    req = 4'b1111;
    push(4'b0001, 4'h1);
    push(4'b0010, 4'h2);
    push(4'b0100, 4'h3);
    push(4'b1000, 4'h4);
    for (int i = 0; i < 30 && req != 4'b0000; i++) begin
      step();
      req = req & ~ack;
    end
    check("all_req_done", 32'(req), 0);
    step();
    check("all_req_idle_gnt", 32'(gnt), 0);

    // Single-grant vectors.
    for (int i = 0; i < 8; i++) begin
      set_words(vecs[i].ws);
      req = vecs[i].req;
      step();
      check("vec_gnt", 32'(gnt), 32'(vecs[i].gnt));
      check("vec_sel", 32'(sel), 32'(vecs[i].sel));
      check("vec_busy", 32'(busy), 1);
      push(vecs[i].gnt, vecs[i].y);
      step();
      check("vec_y", 32'(y), 32'(vecs[i].y));
      req = 4'b0000;
      step();
      check("vec_release_gnt", 32'(gnt), 0);
      check("vec_release_busy", 32'(busy), 0);
      check("vec_consumed", 32'(y_valid), 0);
    end

    // Back-pressure: second grant stalls until out_ready rises.
    out_ready = 1'b0;
    set_words(16'h0903);
    req = 4'b0001;
    push(4'b0001, 4'h3);
    step();
    check("bp_gnt0", 32'(gnt), 'h1);
    step();
    req = 4'b0100;
    step();
    check("bp_gnt2", 32'(gnt), 'h4);
    check("bp_valid_held", 32'(y_valid), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall", 32'({gnt, ack, y, y_valid}), 32'({4'b0100, 4'b0000, 4'h3, 1'b1}));
    end
    push(4'b0100, 4'h9);
    out_ready = 1'b1;
    step();
    check("bp_load_consume", 32'({y, y_valid}), 32'({4'h9, 1'b1}));
    req = 4'b0000;
    step();
    check("bp_drained", 32'({gnt, y_valid}), 0);

    // Reset between grant and load.
    out_ready = 1'b0;
    set_words(16'h0050);
    req = 4'b0010;
    step();
    check("rst_mid_gnt", 32'(gnt), 'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", 32'({gnt, ack, y_valid, busy}), 0);
    req = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    set_words(16'h9876);
    req       = 4'b1111;
    out_ready = 1'b1;
    push(4'b0001, 4'h6);
    step();
    check("rst_ptr_ch0", 32'(gnt), 'h1);
    step();
    req = 4'b0000;
    step();
    check("rst_after_gnt", 32'(gnt), 0);

    // ch2 locked with ch0 also requesting; ptr is 1 here.
    set_words(16'h0C01);
    req  = 4'b0101;
    lock = 4'b0100;
    for (int i = 0; i < ExpBeats; i++) push(4'b0100, 4'hC);
    push(4'b0001, 4'h1);
    cnt2   = 0;
    cnt0   = 0;
    first2 = -1;
    last2  = -1;
    cyc    = 0;
    for (int i = 0; i < 20 && req != 4'b0000; i++) begin
      step();
      cyc++;
      if (ack[2]) begin
        if (first2 < 0) first2 = cyc;
        last2 = cyc;
        cnt2++;
        if (cnt2 == ExpBeats) begin
          req[2] = 1'b0;
          lock   = 4'b0000;
        end
      end
      if (ack[0]) begin
        cnt0++;
        req[0] = 1'b0;
      end
    end
    check("lock_ch2_beats", 32'(cnt2), 32'(ExpBeats));
    check("lock_ch2_consecutive", 32'(last2 - first2), 32'(ExpBeats - 1));
    check("lock_ch0_served", 32'(cnt0), 1);
    step();
    check("lock_idle", 32'({gnt, busy}), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
